// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle RV64 main control FSM (fetch/decode/execute/memory/writeback) with memory timeout and illegal-opcode trap; define INSTR_COUNT_EN to add the 64-bit retired_count output
module multi_cycle_control #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [1:0]  ctrl_ALU_op,
   output logic        ctrl_alu_src_a,
   output logic [1:0]  ctrl_alu_src_b,
   output logic        ctrl_mem_read,
   output logic        ctrl_mem_write,
   output logic        ctrl_ir_write,
   output logic        ctrl_pc_write,
   output logic        ctrl_reg_write,
   output logic        ctrl_mem_to_reg,
   output logic [1:0]  trap_cause,
`ifdef INSTR_COUNT_EN
   output logic [63:0] retired_count,
`endif
   output logic [3:0]  state
);
   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      MEM_WR   = 4'd5,
      WB_LD    = 4'd6,
      EXEC_R   = 4'd7,
      WB_R     = 4'd8,
      BRANCH   = 4'd9,
      TRAP     = 4'd15
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [1:0]      trap_q, trap_d;
   logic            wait_st, timeout, legal;
`ifdef INSTR_COUNT_EN
   logic [63:0]     retired_q;
   logic            retire;
`endif

   assign wait_st = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
   assign timeout = wait_cnt_q == CW'(MEM_TIMEOUT - 1);
   assign legal   = (opcode == OP_R) || (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_BR);
   assign state      = state_q;
   assign trap_cause = trap_q;
`ifdef INSTR_COUNT_EN
   assign retire = (state_d == FETCH) && ((state_q == WB_LD) || (state_q == WB_R) || (state_q == MEM_WR) || (state_q == BRANCH));
   assign retired_count = retired_q;
`endif

   // state, wait counter, trap cause and retire counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         trap_q     <= 2'b00;
`ifdef INSTR_COUNT_EN
         retired_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         trap_q     <= trap_d;
`ifdef INSTR_COUNT_EN
         retired_q  <= retire ? retired_q + 64'd1 : retired_q;
`endif
      end
   end

   // next state; mem_ready beats timeout, wait counter clears on any state change
   always_comb begin
      state_d = state_q;
      trap_d  = trap_q;
      case (state_q)
         IDLE:     state_d = FETCH;
         FETCH:    state_d = mem_ready ? DECODE : timeout ? TRAP : FETCH;
         DECODE:   state_d = (opcode == OP_R) ? EXEC_R :
                             ((opcode == OP_LD) || (opcode == OP_ST)) ? MEM_ADDR :
                             (opcode == OP_BR) ? BRANCH : TRAP;
         MEM_ADDR: state_d = (opcode == OP_LD) ? MEM_RD : MEM_WR;
         MEM_RD:   state_d = mem_ready ? WB_LD : timeout ? TRAP : MEM_RD;
         MEM_WR:   state_d = mem_ready ? FETCH : timeout ? TRAP : MEM_WR;
         WB_LD:    state_d = FETCH;
         EXEC_R:   state_d = WB_R;
         WB_R:     state_d = FETCH;
         BRANCH:   state_d = FETCH;
         default:  state_d = state_q;
      endcase
      if (state_q == DECODE && !legal)
         trap_d = 2'b01;
      if (wait_st && !mem_ready && timeout)
         trap_d = 2'b10;
      wait_cnt_d = (wait_st && state_d == state_q) ? wait_cnt_q + 1'b1 : '0;
   end

   // Moore strobes from the state register, plus mem_ready/zero gated PC and IR writes
   always_comb begin
      ctrl_ALU_op     = 2'b00;
      ctrl_alu_src_a  = 1'b0;
      ctrl_alu_src_b  = 2'b00;
      ctrl_mem_read   = 1'b0;
      ctrl_mem_write  = 1'b0;
      ctrl_ir_write   = 1'b0;
      ctrl_pc_write   = 1'b0;
      ctrl_reg_write  = 1'b0;
      ctrl_mem_to_reg = 1'b0;
      case (state_q)
         FETCH: begin
            ctrl_mem_read  = 1'b1;
            ctrl_alu_src_b = 2'b01;
            ctrl_ir_write  = mem_ready;
            ctrl_pc_write  = mem_ready;
         end
         MEM_ADDR, MEM_RD, MEM_WR: begin
            ctrl_alu_src_a = 1'b1;
            ctrl_alu_src_b = 2'b10;
            ctrl_mem_read  = state_q == MEM_RD;
            ctrl_mem_write = state_q == MEM_WR;
         end
         WB_LD: begin
            ctrl_reg_write  = 1'b1;
            ctrl_mem_to_reg = 1'b1;
         end
         EXEC_R, WB_R: begin
            ctrl_alu_src_a = 1'b1;
            ctrl_ALU_op    = 2'b10;
            ctrl_reg_write = state_q == WB_R;
         end
         BRANCH: begin
            ctrl_alu_src_a = 1'b1;
            ctrl_ALU_op    = 2'b01;
            ctrl_pc_write  = zero;
         end
         default: ;
      endcase
   end
endmodule
